// File: rtl/pwm_frame_decoder.sv
// -----------------------------------------------------------------------------
// pwm_frame_decoder
//
// Receive-side counterpart of the serial PWM frame transmitter. Deserializes
// each latched frame of NUM_CH bits, counts high frames per channel over
// PERIOD accepted frames, and then emits the per-channel counts one channel
// at a time over a valid/ready port.
//
// Ports:
//   clk         system clock, all logic on posedge
//   reset       synchronous active-high reset
//   s_in        serial PWM bit, shifted in every cycle
//   latch       frame strobe (frame = this cycle's bit + previous NUM_CH-1)
//   duty_out    measured high-frame count of channel duty_ch
//   duty_ch     channel index of duty_out
//   duty_valid  result valid
//   duty_ready  result ready
//   overrun     one-cycle pulse when a period snapshot is dropped
//   frame_err   (FRAME_CHECK_EN only) one-cycle pulse on a mistimed latch
//
// Build option: define FRAME_CHECK_EN to accept only latches that arrive
// exactly NUM_CH cycles after the previous latch (or after reset release).
// -----------------------------------------------------------------------------
module pwm_frame_decoder #(
  parameter int NUM_CH = 8,
  parameter int PERIOD = 101,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_in,
  input  logic                      latch,
  output logic [CNT_W-1:0]          duty_out,
  output logic [$clog2(NUM_CH)-1:0] duty_ch,
  output logic                      duty_valid,
  input  logic                      duty_ready,
  output logic                      overrun
`ifdef FRAME_CHECK_EN
  ,
  output logic                      frame_err
`endif
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int FC_W = $clog2(PERIOD + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  logic [NUM_CH-1:0] shift_q;
  logic [NUM_CH-1:0] frame_bits;
  logic [CNT_W-1:0]  hi_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  hi_upd   [NUM_CH];
  logic [CNT_W-1:0]  res_q    [NUM_CH];
  logic [FC_W-1:0]   frame_cnt_q;
  logic              frame_ok;
  logic              frame_accept;
  logic              period_done;
  logic              snap_take;
  logic              handshake;
  logic              last_hs;
  logic              overrun_q;
  state_t            state_q, state_d;
  logic [CH_W-1:0]   duty_ch_q, duty_ch_d;

  // Newest bit enters at the MSB so that, in the latch cycle, bit c of the
  // frame is channel c (oldest sample = channel 0).
  assign frame_bits = {s_in, shift_q[NUM_CH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) shift_q <= '0;
    else       shift_q <= frame_bits;
  end

`ifdef FRAME_CHECK_EN
  localparam int GAP_W = $clog2(NUM_CH + 1);
  logic [GAP_W-1:0] gap_q;
  logic             frame_err_q;

  // gap_q = cycles elapsed since the last latch (or reset release);
  // saturates at NUM_CH, which is already a bad gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      if (latch)                         gap_q <= '0;
      else if (gap_q != GAP_W'(NUM_CH))  gap_q <= gap_q + 1'b1;
      frame_err_q <= latch & ~frame_ok;
    end
  end

  assign frame_ok  = (gap_q == GAP_W'(NUM_CH - 1));
  assign frame_err = frame_err_q;
`else
  assign frame_ok = 1'b1;
`endif

  assign frame_accept = latch & frame_ok;
  assign period_done  = frame_accept && (frame_cnt_q == FC_W'(PERIOD - 1));

  // Counts including the current frame; this is also the snapshot value so
  // the period-completing frame is part of the reported result.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign hi_upd[gi] = (frame_accept && frame_bits[gi] && (hi_cnt_q[gi] != CNT_MAX))
                        ? hi_cnt_q[gi] + 1'b1 : hi_cnt_q[gi];
  end

  assign handshake = (state_q == EMIT) && duty_ready;
  assign last_hs   = handshake && (duty_ch_q == CH_W'(NUM_CH - 1));
  // A snapshot is taken when the emitter is free, including the edge on
  // which it hands over its final channel.
  assign snap_take = period_done && ((state_q == IDLE) || last_hs);

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        hi_cnt_q[i] <= '0;
        res_q[i]    <= '0;
      end
    end else begin
      overrun_q <= period_done & ~snap_take;
      if (period_done)       frame_cnt_q <= '0;
      else if (frame_accept) frame_cnt_q <= frame_cnt_q + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        hi_cnt_q[i] <= period_done ? '0 : hi_upd[i];
        if (snap_take) res_q[i] <= hi_upd[i];
      end
    end
  end

  // Emitter FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      duty_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      duty_ch_q <= duty_ch_d;
    end
  end

  // Emitter FSM: next state
  always_comb begin
    state_d   = state_q;
    duty_ch_d = duty_ch_q;
    case (state_q)
      IDLE: begin
        if (snap_take) begin
          state_d   = EMIT;
          duty_ch_d = '0;
        end
      end
      EMIT: begin
        if (last_hs) begin
          state_d   = snap_take ? EMIT : IDLE;
          duty_ch_d = '0;
        end else if (handshake) begin
          duty_ch_d = duty_ch_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        duty_ch_d = '0;
      end
    endcase
  end

  // Emitter FSM: outputs
  always_comb begin
    duty_valid = 1'b0;
    duty_out   = '0;
    if (state_q == EMIT) begin
      duty_valid = 1'b1;
      duty_out   = res_q[duty_ch_q];
    end
  end

  assign duty_ch = duty_ch_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_pwm_frame_decoder.sv
module tb_pwm_frame_decoder;

  localparam int NUM_CH = 8;
  localparam int PERIOD = 101;

  typedef int duty_t [NUM_CH];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       s_in = 1'b0;
  logic       latch = 1'b0;
  logic       duty_ready = 1'b0;
  logic [7:0] duty_out;
  logic [2:0] duty_ch;
  logic       duty_valid;
  logic       overrun;
  logic [3:0] duty_out4;
  logic [2:0] duty_ch4;
  logic       duty_valid4;
  logic       overrun4;
`ifdef FRAME_CHECK_EN
  logic       frame_err;
  logic       frame_err4;
`endif

  pwm_frame_decoder #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .s_in(s_in), .latch(latch),
    .duty_out(duty_out), .duty_ch(duty_ch), .duty_valid(duty_valid),
    .duty_ready(duty_ready), .overrun(overrun)
`ifdef FRAME_CHECK_EN
    , .frame_err(frame_err)
`endif
  );

  // Narrow-counter instance sharing the same stream, always ready.
  pwm_frame_decoder #(.NUM_CH(NUM_CH), .PERIOD(PERIOD), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .s_in(s_in), .latch(latch),
    .duty_out(duty_out4), .duty_ch(duty_ch4), .duty_valid(duty_valid4),
    .duty_ready(1'b1), .overrun(overrun4)
`ifdef FRAME_CHECK_EN
    , .frame_err(frame_err4)
`endif
  );

  int cmp_cnt = 0;
  int err_cnt = 0;
  int got_ch[$];
  int got_val[$];
  int ovr_cnt = 0;
  int ferr_cnt = 0;

  // Transaction monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (duty_valid && duty_ready) begin
        got_ch.push_back(int'(duty_ch));
        got_val.push_back(int'(duty_out));
        $display("[%0t] result ch=%0d duty=%0d", $time, duty_ch, duty_out);
      end
      if (overrun) ovr_cnt++;
`ifdef FRAME_CHECK_EN
      if (frame_err) ferr_cnt++;
`endif
    end
  end

  task automatic step(input logic b, input logic l);
    s_in  = b;
    latch = l;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    reset = 1'b0;
    got_ch.delete();
    got_val.delete();
    ovr_cnt  = 0;
    ferr_cnt = 0;
  endtask

  // Ideal transmitter frame f: channel c high iff f < d[c]
  function automatic logic [7:0] pat(input duty_t d, input int f);
    logic [7:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = (f < d[c]);
    return r;
  endfunction

  task automatic send_frame(input logic [7:0] bits, input bit rnd_ready);
    for (int c = 0; c < NUM_CH; c++) begin
      if (rnd_ready) duty_ready = ($urandom_range(0, 3) != 0);
      step(bits[c], c == NUM_CH - 1);
    end
  endtask

  duty_t d_ref = '{15, 25, 50, 20, 40, 75, 10, 80};

  task automatic test_reset();
    reset = 1'b1;
    step(1'b1, 1'b1);
    cmp_cnt += 4;
    if (duty_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid: got %0b expected 0", duty_valid); end
    if (duty_out !== 8'd0)   begin err_cnt++; $display("FAIL reset_out: got %0d expected 0", duty_out); end
    if (duty_ch !== 3'd0)    begin err_cnt++; $display("FAIL reset_ch: got %0d expected 0", duty_ch); end
    if (overrun !== 1'b0)    begin err_cnt++; $display("FAIL reset_overrun: got %0b expected 0", overrun); end
    $display("[%0t] test_reset done", $time);
  endtask

  task automatic test_ideal();
    do_reset();
    duty_ready = 1'b1;
    for (int f = 0; f < PERIOD - 1; f++) send_frame(pat(d_ref, f), 1'b0);
    cmp_cnt++;
    if (duty_valid !== 1'b0) begin err_cnt++; $display("FAIL ideal_early_valid: got %0b expected 0", duty_valid); end
    send_frame(pat(d_ref, PERIOD - 1), 1'b0);
    cmp_cnt += 3;
    if (duty_valid !== 1'b1) begin err_cnt++; $display("FAIL ideal_latency_valid: got %0b expected 1", duty_valid); end
    if (duty_ch !== 3'd0)    begin err_cnt++; $display("FAIL ideal_first_ch: got %0d expected 0", duty_ch); end
    if (duty_out !== 8'd15)  begin err_cnt++; $display("FAIL ideal_first_out: got %0d expected 15", duty_out); end
    repeat (12) step(1'b0, 1'b0);
    cmp_cnt++;
    if (got_val.size() != NUM_CH) begin err_cnt++; $display("FAIL ideal_count: got %0d expected %0d", got_val.size(), NUM_CH); end
    for (int i = 0; i < NUM_CH && i < got_val.size(); i++) begin
      cmp_cnt++;
      if (got_ch[i] != i || got_val[i] != d_ref[i]) begin
        err_cnt++;
        $display("FAIL ideal_result: got ch%0d=%0d expected ch%0d=%0d", got_ch[i], got_val[i], i, d_ref[i]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    duty_ready = 1'b0;
    for (int f = 0; f < PERIOD; f++) send_frame(pat(d_ref, f), 1'b0);
    for (int k = 0; k < 20; k++) begin
      cmp_cnt++;
      if (duty_valid !== 1'b1 || duty_ch !== 3'd0 || duty_out !== 8'd15) begin
        err_cnt++;
        $display("FAIL stall_hold: got v=%0b ch=%0d out=%0d expected v=1 ch=0 out=15", duty_valid, duty_ch, duty_out);
      end
      step(1'b0, 1'b0);
    end
    duty_ready = 1'b1;
    repeat (12) step(1'b0, 1'b0);
    cmp_cnt++;
    if (got_val.size() != NUM_CH) begin err_cnt++; $display("FAIL stall_count: got %0d expected %0d", got_val.size(), NUM_CH); end
    for (int i = 0; i < NUM_CH && i < got_val.size(); i++) begin
      cmp_cnt++;
      if (got_ch[i] != i || got_val[i] != d_ref[i]) begin
        err_cnt++;
        $display("FAIL stall_result: got ch%0d=%0d expected ch%0d=%0d", got_ch[i], got_val[i], i, d_ref[i]);
      end
    end
  endtask

  task automatic test_overrun();
    duty_t d2;
    duty_t d3;
    for (int c = 0; c < NUM_CH; c++) begin
      d2[c] = $urandom_range(0, PERIOD);
      d3[c] = $urandom_range(0, PERIOD);
    end
    do_reset();
    duty_ready = 1'b0;
    for (int f = 0; f < PERIOD; f++) send_frame(pat(d_ref, f), 1'b0);
    for (int f = 0; f < PERIOD; f++) send_frame(pat(d2, f), 1'b0);
    cmp_cnt += 2;
    if (overrun !== 1'b1) begin err_cnt++; $display("FAIL overrun_pulse: got %0b expected 1", overrun); end
    if (duty_out !== 8'd15) begin err_cnt++; $display("FAIL overrun_res_kept: got %0d expected 15", duty_out); end
    duty_ready = 1'b1;
    repeat (12) step(1'b0, 1'b0);
    cmp_cnt++;
    if (got_val.size() != NUM_CH) begin err_cnt++; $display("FAIL overrun_count: got %0d expected %0d", got_val.size(), NUM_CH); end
    for (int i = 0; i < NUM_CH && i < got_val.size(); i++) begin
      cmp_cnt++;
      if (got_ch[i] != i || got_val[i] != d_ref[i]) begin
        err_cnt++;
        $display("FAIL overrun_result: got ch%0d=%0d expected ch%0d=%0d", got_ch[i], got_val[i], i, d_ref[i]);
      end
    end
    // The period after a dropped snapshot must count only its own frames.
    got_ch.delete();
    got_val.delete();
    for (int f = 0; f < PERIOD; f++) send_frame(pat(d3, f), 1'b0);
    repeat (12) step(1'b0, 1'b0);
    cmp_cnt += 2;
    if (ovr_cnt != 1) begin err_cnt++; $display("FAIL overrun_pulses: got %0d expected 1", ovr_cnt); end
    if (got_val.size() != NUM_CH) begin err_cnt++; $display("FAIL after_overrun_count: got %0d expected %0d", got_val.size(), NUM_CH); end
    for (int i = 0; i < NUM_CH && i < got_val.size(); i++) begin
      cmp_cnt++;
      if (got_ch[i] != i || got_val[i] != d3[i]) begin
        err_cnt++;
        $display("FAIL after_overrun_result: got ch%0d=%0d expected ch%0d=%0d", got_ch[i], got_val[i], i, d3[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    duty_t dn;
    for (int c = 0; c < NUM_CH; c++) dn[c] = $urandom_range(0, PERIOD);
    do_reset();
    duty_ready = 1'b1;
    for (int f = 0; f < PERIOD; f++) send_frame(pat(d_ref, f), 1'b0);
    repeat (3) step(1'b0, 1'b0);
    cmp_cnt++;
    if (duty_valid !== 1'b1 || duty_ch !== 3'd3) begin
      err_cnt++;
      $display("FAIL midreset_pre: got v=%0b ch=%0d expected v=1 ch=3", duty_valid, duty_ch);
    end
    duty_ready = 1'b0;
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    cmp_cnt++;
    if (duty_valid !== 1'b0 || duty_ch !== 3'd0) begin
      err_cnt++;
      $display("FAIL midreset_post: got v=%0b ch=%0d expected v=0 ch=0", duty_valid, duty_ch);
    end
    got_ch.delete();
    got_val.delete();
    duty_ready = 1'b1;
    for (int f = 0; f < PERIOD; f++) send_frame(pat(dn, f), 1'b0);
    repeat (12) step(1'b0, 1'b0);
    cmp_cnt++;
    if (got_val.size() != NUM_CH) begin err_cnt++; $display("FAIL midreset_count: got %0d expected %0d", got_val.size(), NUM_CH); end
    for (int i = 0; i < NUM_CH && i < got_val.size(); i++) begin
      cmp_cnt++;
      if (got_ch[i] != i || got_val[i] != dn[i]) begin
        err_cnt++;
        $display("FAIL midreset_result: got ch%0d=%0d expected ch%0d=%0d", got_ch[i], got_val[i], i, dn[i]);
      end
    end
  endtask

  task automatic test_random();
    int exp_q[$];
    int acc[NUM_CH];
    logic [7:0] bits;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < NUM_CH; c++) acc[c] = 0;
      for (int f = 0; f < PERIOD; f++) begin
        bits = 8'($urandom);
        for (int c = 0; c < NUM_CH; c++) acc[c] += int'(bits[c]);
        send_frame(bits, 1'b1);
      end
      for (int c = 0; c < NUM_CH; c++) exp_q.push_back(acc[c]);
    end
    duty_ready = 1'b1;
    repeat (12) step(1'b0, 1'b0);
    cmp_cnt += 2;
    if (ovr_cnt != 0) begin err_cnt++; $display("FAIL random_overrun: got %0d expected 0", ovr_cnt); end
    if (got_val.size() != exp_q.size()) begin err_cnt++; $display("FAIL random_count: got %0d expected %0d", got_val.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_val.size(); i++) begin
      cmp_cnt++;
      if (got_ch[i] != i % NUM_CH || got_val[i] != exp_q[i]) begin
        err_cnt++;
        $display("FAIL random_result: got ch%0d=%0d expected ch%0d=%0d", got_ch[i], got_val[i], i % NUM_CH, exp_q[i]);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    duty_ready = 1'b1;
    for (int f = 0; f < PERIOD; f++) send_frame(8'hFF, 1'b0);
    for (int i = 0; i < NUM_CH; i++) begin
      cmp_cnt++;
      if (duty_valid4 !== 1'b1 || duty_ch4 !== 3'(i) || duty_out4 !== 4'd15) begin
        err_cnt++;
        $display("FAIL saturate_result: got v=%0b ch=%0d out=%0d expected v=1 ch=%0d out=15", duty_valid4, duty_ch4, duty_out4, i);
      end
      step(1'b0, 1'b0);
    end
    repeat (4) step(1'b0, 1'b0);
    cmp_cnt++;
    if (got_val.size() != NUM_CH || got_val[0] != PERIOD) begin
      err_cnt++;
      $display("FAIL wide_all_high: got n=%0d first=%0d expected n=%0d first=%0d", got_val.size(),
               (got_val.size() > 0) ? got_val[0] : -1, NUM_CH, PERIOD);
    end
  endtask

`ifdef FRAME_CHECK_EN
  task automatic test_frame_err();
    int acc[NUM_CH];
    logic [7:0] bits;
    localparam int BAD = 30;
    for (int c = 0; c < NUM_CH; c++) acc[c] = 0;
    do_reset();
    duty_ready = 1'b1;
    for (int f = 0; f <= PERIOD; f++) begin
      bits = pat(d_ref, f);
      if (f == BAD) begin
        // short frame: latch one cycle early, not counted
        for (int c = 0; c < NUM_CH - 1; c++) step(bits[c], c == NUM_CH - 2);
      end else begin
        for (int c = 0; c < NUM_CH; c++) acc[c] += int'(bits[c]);
        send_frame(bits, 1'b0);
      end
      if (f == PERIOD - 1) begin
        cmp_cnt++;
        if (duty_valid !== 1'b0) begin err_cnt++; $display("FAIL ferr_early_valid: got %0b expected 0", duty_valid); end
      end
    end
    cmp_cnt++;
    if (duty_valid !== 1'b1) begin err_cnt++; $display("FAIL ferr_late_valid: got %0b expected 1", duty_valid); end
    repeat (12) step(1'b0, 1'b0);
    cmp_cnt += 2;
    if (ferr_cnt != 1) begin err_cnt++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt); end
    if (got_val.size() != NUM_CH) begin err_cnt++; $display("FAIL ferr_count: got %0d expected %0d", got_val.size(), NUM_CH); end
    for (int i = 0; i < NUM_CH && i < got_val.size(); i++) begin
      cmp_cnt++;
      if (got_ch[i] != i || got_val[i] != acc[i]) begin
        err_cnt++;
        $display("FAIL ferr_result: got ch%0d=%0d expected ch%0d=%0d", got_ch[i], got_val[i], i, acc[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ideal();
    test_stall();
    test_overrun();
    test_reset_mid();
    test_random();
    test_saturate();
`ifdef FRAME_CHECK_EN
    test_frame_err();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pwm_frame_decoder.md
Name: pwm_frame_decoder

Overview:
- Receive-side counterpart of the serial PWM frame transmitter.
- Accepts the serial bit stream (s_in) and frame strobe (latch) that feed the channel shift register, and deserializes each frame into NUM_CH channel bits.
- Accumulates high-bit counts per channel over PERIOD frames, then reports the measured duty of each channel through a valid/ready result port.
- Used for on-chip self-check and for readback of the programmed duty ratios.

Parameters:
- NUM_CH, 8: channels per serial frame (frame length in bits).
- PERIOD, 101: frames per PWM period (transmitter counter 0..100).
- CNT_W, 8: width of per-channel high counters and of duty_out.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- s_in  input  1  serial PWM bit, sampled every posedge.
- latch  input  1  frame strobe, sampled every posedge.
- duty_out  output  CNT_W  measured high-frame count of channel duty_ch.
- duty_ch  output  $clog2(NUM_CH)  channel index of duty_out.
- duty_valid  output  1  result handshake valid.
- duty_ready  input  1  result handshake ready.
- overrun  output  1  one-cycle pulse when a period snapshot is dropped.
- frame_err  output  1  present only with FRAME_CHECK_EN (see below).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: all outputs 0; shift buffer, hi_cnt[], frame counter, FSM and result registers cleared. Reset mid-handshake drops pending results without completing them.
- Shift buffer: NUM_CH bits. s_in is shifted in every cycle, including latch cycles.
- Frame definition: on a latch=1 posedge, the frame is the bits sampled in that cycle and the previous NUM_CH-1 cycles. The oldest bit is channel 0; the bit sampled in the latch cycle is channel NUM_CH-1. Cycles before reset deassertion contribute zeros.
- Accepted frame:
  - For each channel whose bit is 1, hi_cnt[ch] increments, saturating at 2^CNT_W-1.
  - frame_cnt increments.
- Period completion: when the accepted frame brings frame_cnt to PERIOD (that frame's bits included):
  - snapshot hi_cnt[] into res[];
  - clear hi_cnt[] and frame_cnt in the same edge;
  - request emission.
- FSM states:
  - IDLE: duty_valid=0. On a snapshot request, go to EMIT with duty_ch=0.
  - EMIT: duty_valid=1, duty_out=res[duty_ch].
    - valid&ready with duty_ch<NUM_CH-1: duty_ch++.
    - valid&ready with duty_ch==NUM_CH-1: go to IDLE, duty_ch=0.
- Latency: duty_valid rises the cycle after the period-completing latch edge.
- While valid and not ready, duty_out and duty_ch hold stable.
- Snapshot request while in EMIT: the new snapshot is discarded, res[] is unchanged, and overrun pulses high for 1 cycle. Accumulation for the next period proceeds normally.
- Same edge as the final handshake (EMIT->IDLE) plus a snapshot request: the snapshot is accepted, there is no overrun, and the FSM re-enters EMIT at ch 0 next cycle.
- latch held high for consecutive cycles: each cycle is a separate latch event (subject to frame check when enabled).

Optional Feature:
- Macro: FRAME_CHECK_EN.
- With the macro defined:
  - gap counter counts cycles since the last latch event, or since reset deassert.
  - A latch is accepted only if it occurs exactly NUM_CH cycles after the previous event (first latch: the NUM_CH-th cycle after reset deasserts).
  - Otherwise frame_err pulses 1 cycle, the frame is not counted (hi_cnt and frame_cnt unchanged), and the gap counter restarts.
- Without the macro: frame_err port is absent and every latch is accepted.

Test Plan:
- Ideal stream, NUM_CH=8, PERIOD=101, channel c high in frame f iff f<D[c], D={15,25,50,20,40,75,10,80}, duty_ready=1 -> duty_valid one cycle after the 101st latch; duty_ch 0..7 on 8 consecutive cycles with duty_out 15,25,50,20,40,75,10,80.
- Same stream, duty_ready=0 for 20 cycles then 1 -> duty_out/duty_ch held at ch0=15 during the stall; then full sequence in order, no loss.
- duty_ready=0 across two full periods -> one overrun pulse at the second period's final latch; results afterwards equal the first period.
- Assert reset for 1 cycle during EMIT at duty_ch=3 -> duty_valid=0 next cycle; a fresh 101-frame stream yields correct values from ch0.
- CNT_W=4, all channels constantly high for 101 frames -> every duty_out=15 (saturated).
- FRAME_CHECK_EN: one latch at gap 7 within the stream -> one frame_err pulse; affected period reports D[c] minus that frame's bits; period completes one accepted frame later.
